cp0_irq_ctrl: RTL and testbench
===============================

CP0_IRQ_CTRL -- requirements
Module: cp0_irq_ctrl

Interface
REQ-001 SHALL have port Clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port Clr, input, 1, reset, asynchronous, active-high.
REQ-003 SHALL have port HWInt, input, 6, hardware interrupt lines, level-sensitive.
REQ-004 SHALL have port PCM, input, 32, PC of the instruction in the M stage.
REQ-005 SHALL have port ValidM, input, 1, M-stage instruction is real (not a bubble).
REQ-006 SHALL have port BDM, input, 1, M-stage instruction sits in a branch delay slot.
REQ-007 SHALL have port WE, input, 1, mtc0 write strobe.
REQ-008 SHALL have port A, input, 5, CP0 register number for mtc0/mfc0.
REQ-009 SHALL have port DIn, input, 32, mtc0 write data.
REQ-010 SHALL have port ERET, input, 1, eret in M stage, with ValidM high.
REQ-011 SHALL have port DOut, output, 32, mfc0 read data, combinational on A.
REQ-012 SHALL have port InterruptRequest, output, 1, registered one-cycle PC redirect pulse to the PC register.
REQ-013 SHALL have port RedirectPC, output, 32, target presented to the PC input mux.
REQ-014 SHALL have port RedirectEn, output, 1, RedirectPC is valid this cycle (interrupt or eret).
REQ-015 SHALL have parameter HANDLER, default 32'h00004180, interrupt handler entry address.

Function
REQ-016 SHALL implement SR (A=12), Cause (A=13), EPC (A=14) and PrID (A=15, constant 32'h4D495053); any other A SHALL read 0.
REQ-017 SR fields SHALL be IM=[15:10], EXL=[1] and IE=[0]; all other SR bits SHALL read 0.
REQ-018 Cause fields SHALL be BD=[31], IP=[15:10] and ExcCode=[6:2]; ExcCode SHALL always be 0; all other Cause bits SHALL read 0.
REQ-019 Cause.IP SHALL be loaded from HWInt every cycle.
REQ-020 Writes to Cause SHALL be ignored.
REQ-021 Pending SHALL be |(HWInt & SR.IM) & SR.IE & ~SR.EXL, computed from the current, not registered, HWInt.
REQ-022 SHALL use FSM states IDLE, ENTER and HANDLER.
REQ-023 IDLE -> ENTER SHALL occur when Pending and ValidM are both high and ERET is low.
REQ-024 On the IDLE -> ENTER edge, EPC SHALL load BDM ? PCM-4 : PCM, with bits [1:0] forced to 0.
REQ-025 On the IDLE -> ENTER edge, Cause.BD SHALL load BDM and SR.EXL SHALL be set to 1.
REQ-026 In ENTER: InterruptRequest=1, RedirectEn=1 and RedirectPC=HANDLER, for exactly one cycle; the next state SHALL be HANDLER.
REQ-027 In HANDLER, ERET with ValidM SHALL, in the same cycle, drive RedirectEn=1 and RedirectPC=EPC; on that edge SR.EXL SHALL clear and the state SHALL return to IDLE.
REQ-028 InterruptRequest SHALL be 0 during the eret redirect.
REQ-029 ERET seen in IDLE (EXL already 0) SHALL still redirect to EPC and SHALL leave the state in IDLE.
REQ-030 In the cycle of the IDLE -> ENTER edge, a simultaneous mtc0 to SR or EPC SHALL be discarded, so that interrupt entry wins.
REQ-031 When ERET and Pending coincide in IDLE, ERET SHALL win and Pending SHALL be re-evaluated next cycle.
REQ-032 mtc0 to EPC SHALL store DIn with [1:0] forced to 0.
REQ-033 mtc0 to SR SHALL write only the IM, EXL and IE fields.
REQ-034 An mtc0 that sets IE while a line is already pending SHALL cause entry no earlier than the following cycle.
REQ-035 Pending with ValidM=0 (bubble) SHALL hold IDLE until a valid M instruction arrives.
REQ-036 HWInt deasserting while in ENTER or HANDLER SHALL not alter the flow.
REQ-037 RedirectEn and RedirectPC SHALL be 0 whenever no redirect is active.

Reset
REQ-038 Clr high SHALL immediately force state IDLE, SR=0, EPC=0, Cause.BD=0, InterruptRequest=0, RedirectEn=0 and RedirectPC=0.
REQ-039 Clr high SHALL cause Cause.IP to read 0 while Clr is held.
REQ-040 Clr asserted during ENTER SHALL abort the pulse in the same cycle.
REQ-041 After Clr releases, the first possible entry SHALL be on the first clock edge with Pending high.

Verification
REQ-042 SR=32'h00000401, HWInt=6'b000001, ValidM=1, PCM=32'h00003010, BDM=0 -> next cycle InterruptRequest=1 and RedirectPC=32'h00004180; EPC=32'h00003010; SR.EXL=1; state HANDLER after that.
REQ-043 Same as REQ-042 but BDM=1, PCM=32'h00003014 -> EPC=32'h00003010 and Cause=32'h80000400.
REQ-044 From HANDLER with EPC=32'h00003010, ERET=1 -> same cycle RedirectEn=1 and RedirectPC=32'h00003010; next cycle SR.EXL=0 and state IDLE; InterruptRequest stays 0.
REQ-045 Pending with WE=1, A=14, DIn=32'h12345677 in the entry cycle -> EPC=PCM (write discarded); a later mtc0 with no interrupt -> EPC reads 32'h12345674.
REQ-046 HWInt active, SR.IE=0, then mtc0 SR=32'h0000FC01 -> no entry in the write cycle; InterruptRequest pulses one cycle later.
REQ-047 Clr asserted asynchronously mid-ENTER -> InterruptRequest drops without waiting for a clock edge; mfc0 of A=12 returns 0 and A=15 returns 32'h4D495053.

Source files
------------

// File: rtl/cp0_irq_ctrl.sv
// CP0 interrupt controller: SR/Cause/EPC/PrID registers plus interrupt-entry and eret
// redirect sequencing for the M stage.
module cp0_irq_ctrl #(
    parameter logic [31:0] HANDLER = 32'h00004180
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [5:0]  HWInt,
    input  logic [31:0] PCM,
    input  logic        ValidM,
    input  logic        BDM,
    input  logic        WE,
    input  logic [4:0]  A,
    input  logic [31:0] DIn,
    input  logic        ERET,
    output logic [31:0] DOut,
    output logic        InterruptRequest,
    output logic [31:0] RedirectPC,
    output logic        RedirectEn
);

    typedef enum logic [1:0] {ST_IDLE, ST_ENTER, ST_HANDLER} state_t;

    localparam logic [31:0] PRID = 32'h4D495053;

    state_t      state_q, state_d;
    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic [31:0] epc_q, epc_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;

    logic        pending;
    logic        eret_go;
    logic        enter_go;
    logic [31:0] epc_entry;
    logic        irq_c;
    logic        ren_c;
    logic [31:0] rpc_c;

    assign pending   = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign eret_go   = ERET & ValidM & (state_q != ST_ENTER);
    // eret takes priority over a coincident pending line; it is re-evaluated next cycle
    assign enter_go  = (state_q == ST_IDLE) & pending & ValidM & ~ERET;
    assign epc_entry = BDM ? (PCM - 32'd4) : PCM;
    assign ip_d      = HWInt;

    always_comb begin
        state_d = state_q;
        im_d    = im_q;
        exl_d   = exl_q;
        ie_d    = ie_q;
        epc_d   = epc_q;
        bd_d    = bd_q;
        irq_c   = 1'b0;
        ren_c   = 1'b0;
        rpc_c   = 32'h0;

        if (WE && !enter_go) begin
            if (A == 5'd12) begin
                im_d  = DIn[15:10];
                exl_d = DIn[1];
                ie_d  = DIn[0];
            end else if (A == 5'd14) begin
                epc_d = {DIn[31:2], 2'b00};
            end
        end

        if (eret_go) begin
            exl_d = 1'b0;
            ren_c = 1'b1;
            rpc_c = epc_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (enter_go) begin
                    state_d = ST_ENTER;
                    epc_d   = {epc_entry[31:2], 2'b00};
                    bd_d    = BDM;
                    exl_d   = 1'b1;
                end
            end
            ST_ENTER: begin
                state_d = ST_HANDLER;
                irq_c   = 1'b1;
                ren_c   = 1'b1;
                rpc_c   = HANDLER;
            end
            ST_HANDLER: begin
                if (eret_go) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q <= ST_IDLE;
            im_q    <= 6'h0;
            exl_q   <= 1'b0;
            ie_q    <= 1'b0;
            epc_q   <= 32'h0;
            bd_q    <= 1'b0;
            ip_q    <= 6'h0;
        end else begin
            state_q <= state_d;
            im_q    <= im_d;
            exl_q   <= exl_d;
            ie_q    <= ie_d;
            epc_q   <= epc_d;
            bd_q    <= bd_d;
            ip_q    <= ip_d;
        end
    end

    // Gating with Clr keeps a combinational eret redirect from leaking out during reset
    assign InterruptRequest = irq_c & ~Clr;
    assign RedirectEn       = ren_c & ~Clr;
    assign RedirectPC       = Clr ? 32'h0 : rpc_c;

    always_comb begin
        DOut = 32'h0;
        case (A)
            5'd12:   DOut = {16'h0, im_q, 8'h0, exl_q, ie_q};
            5'd13:   DOut = {bd_q, 15'h0, ip_q, 10'h0};
            5'd14:   DOut = epc_q;
            5'd15:   DOut = PRID;
            default: DOut = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed table-driven bench for cp0_irq_ctrl, plus a hand-written async-clear sequence.
module tb_cp0_irq_ctrl;

    logic        Clk = 1'b0;
    logic        Clr;
    logic [5:0]  HWInt;
    logic [31:0] PCM;
    logic        ValidM;
    logic        BDM;
    logic        WE;
    logic [4:0]  A;
    logic [31:0] DIn;
    logic        ERET;
    logic [31:0] DOut;
    logic        InterruptRequest;
    logic [31:0] RedirectPC;
    logic        RedirectEn;

    int n_vec = 0;
    int n_bad = 0;

    cp0_irq_ctrl dut (
        .Clk(Clk), .Clr(Clr), .HWInt(HWInt), .PCM(PCM), .ValidM(ValidM), .BDM(BDM),
        .WE(WE), .A(A), .DIn(DIn), .ERET(ERET), .DOut(DOut),
        .InterruptRequest(InterruptRequest), .RedirectPC(RedirectPC), .RedirectEn(RedirectEn)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        clr;
        logic [5:0]  hw;
        logic [31:0] pcm;
        logic        vm;
        logic        bdm;
        logic        we;
        logic [4:0]  a;
        logic [31:0] din;
        logic        eret;
        logic [31:0] e_dout;
        logic        e_irq;
        logic        e_ren;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic clr, logic [5:0] hw, logic [31:0] pcm, logic vm, logic bdm,
                                logic we, logic [4:0] a, logic [31:0] din, logic eret,
                                logic [31:0] e_dout, logic e_irq, logic e_ren, logic [31:0] e_rpc);
        vec_t v;
        v.clr = clr; v.hw = hw; v.pcm = pcm; v.vm = vm; v.bdm = bdm; v.we = we; v.a = a;
        v.din = din; v.eret = eret; v.e_dout = e_dout; v.e_irq = e_irq; v.e_ren = e_ren;
        v.e_rpc = e_rpc;
        return v;
    endfunction

    task automatic drive(logic clr, logic [5:0] hw, logic [31:0] pcm, logic vm, logic bdm,
                         logic we, logic [4:0] a, logic [31:0] din, logic eret);
        Clr = clr; HWInt = hw; PCM = pcm; ValidM = vm; BDM = bdm; WE = we; A = a; DIn = din;
        ERET = eret;
    endtask

    task automatic check(string name, logic [31:0] e_dout, logic e_irq, logic e_ren,
                         logic [31:0] e_rpc);
        n_vec++;
        if (DOut !== e_dout || InterruptRequest !== e_irq || RedirectEn !== e_ren ||
            RedirectPC !== e_rpc) begin
            n_bad++;
            $display("FAIL %s: got dout=%h irq=%b ren=%b rpc=%h, want dout=%h irq=%b ren=%b rpc=%h",
                     name, DOut, InterruptRequest, RedirectEn, RedirectPC,
                     e_dout, e_irq, e_ren, e_rpc);
        end
    endtask

    initial begin
        drive(1, 6'h01, 0, 0, 0, 0, 5'd12, 0, 0);

        //                 clr hw     pcm           vm bdm we a      din            eret dout          irq ren rpc
        tbl.push_back(mk(1, 6'h01, 32'h0,        0, 0, 0, 5'd12, 32'h0,        0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 6'h01, 32'h0,        0, 0, 0, 5'd13, 32'h0,        0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(0, 6'h01, 32'h0,        0, 0, 0, 5'd15, 32'h0,        0, 32'h4D495053, 0, 0, 32'h0));
        tbl.push_back(mk(0, 6'h01, 32'h0,        0, 0, 0, 5'd13, 32'h0,        0, 32'h00000400, 0, 0, 32'h0));
        tbl.push_back(mk(0, 6'h01, 32'h0,        0, 0, 1, 5'd12, 32'h401,      0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(0, 6'h01, 32'h0,        0, 0, 0, 5'd12, 32'h0,        0, 32'h401,      0, 0, 32'h0));
        tbl.push_back(mk(0, 6'h01, 32'h3010,     1, 0, 1, 5'd14, 32'h12345677, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(0, 6'h00, 32'h0,        1, 0, 0, 5'd14, 32'h0,        0, 32'h3010,     1, 1, 32'h4180));
        tbl.push_back(mk(0, 6'h00, 32'h0,        1, 0, 0, 5'd12, 32'h0,        0, 32'h403,      0, 0, 32'h0));
        tbl.push_back(mk(0, 6'h00, 32'h0,        1, 0, 0, 5'd13, 32'h0,        0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(0, 6'h00, 32'h0,        1, 0, 0, 5'd14, 32'h0,        1, 32'h3010,     0, 1, 32'h3010));
        tbl.push_back(mk(0, 6'h00, 32'h0,        1, 0, 0, 5'd12, 32'h0,        0, 32'h401,      0, 0, 32'h0));
        tbl.push_back(mk(0, 6'h00, 32'h0,        1, 0, 1, 5'd14, 32'h12345677, 0, 32'h3010,     0, 0, 32'h0));
        tbl.push_back(mk(0, 6'h00, 32'h0,        1, 0, 0, 5'd14, 32'h0,        0, 32'h12345674, 0, 0, 32'h0));
        tbl.push_back(mk(0, 6'h01, 32'h3014,     1, 1, 0, 5'd13, 32'h0,        0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(0, 6'h01, 32'h0,        1, 0, 0, 5'd13, 32'h0,        0, 32'h80000400, 1, 1, 32'h4180));
        tbl.push_back(mk(0, 6'h01, 32'h0,        1, 0, 0, 5'd14, 32'h0,        0, 32'h3010,     0, 0, 32'h0));
        tbl.push_back(mk(0, 6'h01, 32'h0,        0, 0, 0, 5'd12, 32'h0,        1, 32'h403,      0, 0, 32'h0));
        tbl.push_back(mk(0, 6'h01, 32'h0,        1, 0, 0, 5'd12, 32'h0,        1, 32'h403,      0, 1, 32'h3010));
        tbl.push_back(mk(0, 6'h01, 32'h0,        1, 0, 0, 5'd12, 32'h0,        1, 32'h401,      0, 1, 32'h3010));
        tbl.push_back(mk(0, 6'h01, 32'h3020,     1, 0, 0, 5'd14, 32'h0,        0, 32'h3010,     0, 0, 32'h0));
        tbl.push_back(mk(0, 6'h01, 32'h0,        1, 0, 0, 5'd14, 32'h0,        0, 32'h3020,     1, 1, 32'h4180));
        tbl.push_back(mk(0, 6'h01, 32'h0,        1, 0, 0, 5'd14, 32'h0,        1, 32'h3020,     0, 1, 32'h3020));
        tbl.push_back(mk(0, 6'h00, 32'h0,        1, 0, 1, 5'd12, 32'hFC00,     0, 32'h401,      0, 0, 32'h0));
        tbl.push_back(mk(0, 6'h01, 32'h0,        1, 0, 0, 5'd12, 32'h0,        0, 32'hFC00,     0, 0, 32'h0));
        tbl.push_back(mk(0, 6'h01, 32'h3040,     1, 0, 1, 5'd12, 32'hFC01,     0, 32'hFC00,     0, 0, 32'h0));
        tbl.push_back(mk(0, 6'h01, 32'h3040,     1, 0, 0, 5'd12, 32'h0,        0, 32'hFC01,     0, 0, 32'h0));
        tbl.push_back(mk(0, 6'h01, 32'h0,        1, 0, 0, 5'd12, 32'h0,        0, 32'hFC03,     1, 1, 32'h4180));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge Clk);
            drive(tbl[i].clr, tbl[i].hw, tbl[i].pcm, tbl[i].vm, tbl[i].bdm, tbl[i].we,
                  tbl[i].a, tbl[i].din, tbl[i].eret);
            #2;
            check($sformatf("vec%0d", i), tbl[i].e_dout, tbl[i].e_irq, tbl[i].e_ren, tbl[i].e_rpc);
        end

        // Leave HANDLER via eret, then re-enter and clear asynchronously mid-pulse
        @(negedge Clk);
        drive(0, 6'h00, 32'h0, 1, 0, 0, 5'd14, 32'h0, 1);
        #2 check("eret_from_handler", 32'h3040, 0, 1, 32'h3040);
        @(negedge Clk);
        drive(0, 6'h01, 32'h3050, 1, 0, 0, 5'd14, 32'h0, 0);
        #2 check("entry_cycle", 32'h3040, 0, 0, 32'h0);
        @(negedge Clk);
        drive(0, 6'h01, 32'h0, 1, 0, 0, 5'd12, 32'h0, 0);
        #2 check("enter_pulse", 32'hFC03, 1, 1, 32'h4180);
        Clr = 1'b1;
        #1 check("async_clr_sr", 32'h0, 0, 0, 32'h0);
        A = 5'd15;
        #1 check("async_clr_prid", 32'h4D495053, 0, 0, 32'h0);
        A = 5'd13;
        #1 check("async_clr_cause", 32'h0, 0, 0, 32'h0);

        // After release: enable line 0, then first pending edge enters
        @(negedge Clk);
        drive(0, 6'h00, 32'h0, 1, 0, 1, 5'd12, 32'h401, 0);
        #2 check("post_clr_write", 32'h0, 0, 0, 32'h0);
        @(negedge Clk);
        drive(0, 6'h01, 32'h3060, 1, 0, 0, 5'd12, 32'h0, 0);
        #2 check("post_clr_pending", 32'h401, 0, 0, 32'h0);
        @(negedge Clk);
        drive(0, 6'h01, 32'h0, 1, 0, 0, 5'd14, 32'h0, 0);
        #2 check("post_clr_entry", 32'h3060, 1, 1, 32'h4180);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
